// File: rtl/seg7_display_if.sv
// Result handshake between the ALU result register and the 7-segment display driver.
// master: result producer; slave: display driver.
interface seg7_display_if;
  logic       data_valid;
  logic [7:0] data_in;
  logic       data_signed;
  logic       data_ovf;
  logic       busy;

  modport master (
    output data_valid,
    output data_in,
    output data_signed,
    output data_ovf,
    input  busy
  );

  modport slave (
    input  data_valid,
    input  data_in,
    input  data_signed,
    input  data_ovf,
    output busy
  );
endinterface

// File: rtl/seg7_display_driver.sv
// 8-bit result -> BCD (double-dabble, 1 bit/cycle) -> 4-digit multiplexed 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading hundreds/tens zeros).
module seg7_display_driver #(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_display_if.slave        bus,
  output logic [6:0]           sev_seg,
  output logic [3:0]           anode
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  // Digit registers hold symbols, not segment patterns: 0..9 plus these specials.
  localparam logic [3:0] SYM_DASH  = 4'd10;
  localparam logic [3:0] SYM_F     = 4'd11;
  localparam logic [3:0] SYM_O     = 4'd12;
  localparam logic [3:0] SYM_BLANK = 4'd15;

  function automatic logic [6:0] seg_code(input logic [3:0] sym);
    logic [6:0] code;
    case (sym)
      4'd0:     code = 7'b1000000;
      4'd1:     code = 7'b1111001;
      4'd2:     code = 7'b0100100;
      4'd3:     code = 7'b0110000;
      4'd4:     code = 7'b0011001;
      4'd5:     code = 7'b0010010;
      4'd6:     code = 7'b0000010;
      4'd7:     code = 7'b1111000;
      4'd8:     code = 7'b0000000;
      4'd9:     code = 7'b0010000;
      SYM_DASH: code = 7'b0111111;
      SYM_F:    code = 7'b0001110;
      SYM_O:    code = 7'b1000000;
      default:  code = 7'b1111111;
    endcase
    return code;
  endfunction

  function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
    logic [11:0] adj;
    adj = bcd;
    for (int n = 0; n < 3; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) begin
        adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end else begin
        adj[n*4 +: 4] = bcd[n*4 +: 4];
      end
    end
    return adj;
  endfunction

  logic [1:0]        state_r;
  logic [7:0]        mag_r;
  logic [11:0]       bcd_r;
  logic [2:0]        bit_cnt_r;
  logic              neg_r;
  logic              ovf_r;
  logic              busy_r;
  logic [3:0][3:0]   digit_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        idx_r;
  logic [6:0]        sev_seg_r;
  logic [3:0]        anode_r;

  logic [8:0]        neg_mag_s;
  logic [7:0]        mag_s;
  logic [11:0]       bcd_adj_s;
  logic [3:0][3:0]   digit_next_s;
  logic              cnt_wrap_s;
  logic [1:0]        idx_next_s;

  // Magnitude of the incoming value; 9-bit negate so 0x80 becomes 128.
  always_comb begin
    neg_mag_s = 9'd0 - {1'b0, bus.data_in};
    if (bus.data_signed && bus.data_in[7]) begin
      mag_s = neg_mag_s[7:0];
    end else begin
      mag_s = bus.data_in;
    end
    bcd_adj_s = dabble_adjust(bcd_r);
  end

  // Symbols written to the display registers when a conversion completes.
  always_comb begin
    digit_next_s = {SYM_BLANK, SYM_BLANK, SYM_BLANK, SYM_BLANK};
    if (ovf_r) begin
      digit_next_s = {SYM_BLANK, SYM_O, SYM_F, SYM_BLANK};
    end else begin
      digit_next_s[3] = neg_r ? SYM_DASH : SYM_BLANK;
      digit_next_s[2] = bcd_r[11:8];
      digit_next_s[1] = bcd_r[7:4];
      digit_next_s[0] = bcd_r[3:0];
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_r[11:8] == 4'd0) begin
        digit_next_s[2] = SYM_BLANK;
        if (bcd_r[7:4] == 4'd0) begin
          digit_next_s[1] = SYM_BLANK;
        end else begin
          digit_next_s[1] = bcd_r[7:4];
        end
      end else begin
        digit_next_s[2] = bcd_r[11:8];
      end
`else
      digit_next_s[2] = bcd_r[11:8];
`endif
    end
  end

  // Capture / convert / latch sequencer; strobes outside IDLE are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      mag_r     <= 8'd0;
      bcd_r     <= 12'd0;
      bit_cnt_r <= 3'd0;
      neg_r     <= 1'b0;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      digit_r   <= {SYM_BLANK, SYM_BLANK, SYM_BLANK, SYM_BLANK};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.data_valid) begin
            mag_r     <= mag_s;
            bcd_r     <= 12'd0;
            bit_cnt_r <= 3'd0;
            neg_r     <= bus.data_signed & bus.data_in[7];
            ovf_r     <= bus.data_ovf;
            busy_r    <= 1'b1;
            state_r   <= ST_CONV;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_CONV: begin
          bcd_r     <= {bcd_adj_s[10:0], mag_r[7]};
          mag_r     <= {mag_r[6:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_r <= ST_LATCH;
          end else begin
            state_r <= ST_CONV;
          end
        end
        ST_LATCH: begin
          digit_r <= digit_next_s;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Refresh timing: next digit index, advanced when the dwell counter wraps.
  always_comb begin
    cnt_wrap_s = (cnt_r == CNT_W'(REFRESH_DIV - 1));
    if (cnt_wrap_s) begin
      idx_next_s = idx_r + 2'd1;
    end else begin
      idx_next_s = idx_r;
    end
  end

  // Anode and segment pins are registered from the same index so they change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      idx_r     <= 2'd0;
      anode_r   <= 4'b1110;
      sev_seg_r <= 7'b1111111;
    end else begin
      if (cnt_wrap_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      idx_r     <= idx_next_s;
      anode_r   <= ~(4'b0001 << idx_next_s);
      sev_seg_r <= seg_code(digit_r[idx_next_s]);
    end
  end

  assign bus.busy = busy_r;
  assign sev_seg  = sev_seg_r;
  assign anode    = anode_r;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Directed self-checking bench for seg7_display_driver (REFRESH_DIV = 4).
module tb_seg7_display_driver;

  localparam logic [6:0] C_BL   = 7'b1111111;
  localparam logic [6:0] C_DASH = 7'b0111111;
  localparam logic [6:0] C_0    = 7'b1000000;
  localparam logic [6:0] C_1    = 7'b1111001;
  localparam logic [6:0] C_2    = 7'b0100100;
  localparam logic [6:0] C_5    = 7'b0010010;
  localparam logic [6:0] C_7    = 7'b1111000;
  localparam logic [6:0] C_8    = 7'b0000000;
  localparam logic [6:0] C_9    = 7'b0010000;
  localparam logic [6:0] C_O    = 7'b1000000;
  localparam logic [6:0] C_F    = 7'b0001110;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] C_LZ   = C_BL;
`else
  localparam logic [6:0] C_LZ   = C_0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] sev_seg;
  logic [3:0] anode;
  int         n_cmp = 0;
  int         n_err = 0;

  seg7_display_if bus ();

  seg7_display_driver #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sev_seg (sev_seg),
    .anode   (anode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] d, input logic s, input logic o);
    bus.data_in     = d;
    bus.data_signed = s;
    bus.data_ovf    = o;
    bus.data_valid  = 1'b1;
    tick();
    bus.data_valid  = 1'b0;
  endtask

  // Called right after the accepting edge N: busy after edges N..N+8, low after N+9.
  task automatic busy_window(input string tag);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s_busy%0d", tag, i + 1), 32'(bus.busy), 32'd1);
      tick();
    end
    chk($sformatf("%s_busy_done", tag), 32'(bus.busy), 32'd0);
  endtask

  task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] e [4];
    logic [3:0] tgt;
    int         guard;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int p = 0; p < 4; p++) begin
      tgt   = ~(4'b0001 << p);
      guard = 0;
      while (anode !== tgt && guard < 20) begin
        tick();
        guard++;
      end
      chk($sformatf("%s_an%0d", tag, p), 32'(anode), 32'(tgt));
      chk($sformatf("%s_seg%0d", tag, p), 32'(sev_seg), 32'(e[p]));
    end
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] tgt;
    logic [6:0] rot [4];
    int         guard;

    bus.data_valid  = 1'b0;
    bus.data_in     = 8'd0;
    bus.data_signed = 1'b0;
    bus.data_ovf    = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #20;
    chk("rst_anode", 32'(anode), 32'h0000000e);
    chk("rst_seg", 32'(sev_seg), 32'(C_BL));
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_seg", 32'(sev_seg), 32'(C_BL));

    strobe(8'hFF, 1'b0, 1'b0);
    busy_window("u255");
    tick(); tick();
    check_display("u255", C_BL, C_2, C_5, C_5);

    strobe(8'h80, 1'b1, 1'b0);
    busy_window("s80");
    tick(); tick();
    check_display("s80", C_DASH, C_1, C_2, C_8);

    strobe(8'hF9, 1'b1, 1'b0);
    busy_window("sF9");
    tick(); tick();
    check_display("sF9", C_DASH, C_LZ, C_LZ, C_7);

    // 0x09 arrives at N+4 while converting 0x05 and must be dropped.
    strobe(8'h05, 1'b0, 1'b0);
    tick(); tick(); tick();
    strobe(8'h09, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drop_busy%0d", i), 32'(bus.busy), 32'd1);
      tick();
    end
    chk("drop_busy_done", 32'(bus.busy), 32'd0);
    tick(); tick();
    check_display("drop", C_BL, C_LZ, C_LZ, C_5);

    strobe(8'h21, 1'b0, 1'b0);
    busy_window("u33");
    strobe(8'h09, 1'b0, 1'b0);
    busy_window("acc9");
    tick(); tick();
    check_display("acc9", C_BL, C_LZ, C_LZ, C_9);

    strobe(8'h12, 1'b0, 1'b1);
    busy_window("ovf");
    tick(); tick();
    rot[0] = C_BL; rot[1] = C_F; rot[2] = C_O; rot[3] = C_BL;
    guard = 0;
    prev  = anode;
    tick();
    while (!(prev === 4'b0111 && anode === 4'b1110) && guard < 40) begin
      prev = anode;
      tick();
      guard++;
    end
    chk("rot_sync", 32'(guard < 40), 32'd1);
    for (int k = 0; k < 16; k++) begin
      tgt = ~(4'b0001 << (k / 4));
      chk($sformatf("rot_an%0d", k), 32'(anode), 32'(tgt));
      chk($sformatf("rot_seg%0d", k), 32'(sev_seg), 32'(rot[k / 4]));
      tick();
    end
    chk("rot_wrap", 32'(anode), 32'h0000000e);

    strobe(8'h77, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_anode", 32'(anode), 32'h0000000e);
    chk("mid_rst_seg", 32'(sev_seg), 32'(C_BL));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    check_display("post_rst", C_BL, C_BL, C_BL, C_BL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
